// File: rtl/gf2_mul_sched.sv
// gf2_mul_sched: round-robin scheduler in front of one shared, bit-serial
// GF(2) carry-less multiplier. Each product is returned with the index of
// the requester that supplied the operands.
// Build option: define GF2_REDUCE_EN to reduce every product modulo
// x^WIDTH + POLY. Without it the full 2*WIDTH-1 bit product is returned
// and POLY is ignored.
module gf2_mul_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int TAGW  = 2,
  parameter logic [WIDTH-1:0] POLY = 8'h1B
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic                    flush,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*WIDTH-1:0]      res_data,
  output logic [TAGW-1:0]         res_tag,
  output logic                    busy
);

  localparam int CNTW = $clog2(WIDTH);
`ifdef GF2_REDUCE_EN
  localparam int ACCW = WIDTH;
`else
  localparam int ACCW = 2 * WIDTH - 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [TAGW-1:0]   r_ptr;
  logic [CNTW-1:0]   r_cnt;
  logic [ACCW-1:0]   r_acc;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [TAGW-1:0]   r_tag;

  logic [TAGW-1:0]   w_pos [NREQ];
  logic [WIDTH-1:0]  w_lane_a [NREQ];
  logic [WIDTH-1:0]  w_lane_b [NREQ];
  logic [NREQ-1:0]   w_rot_valid;
  logic [TAGW-1:0]   w_win;
  logic              w_any;
  logic              w_grant_en;
  logic [TAGW-1:0]   w_next_ptr;
  logic [ACCW-1:0]   w_pp;
  logic [ACCW-1:0]   w_acc_next;

  // Position gi of the rotated search order is requester (ptr + gi) mod NREQ.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      logic [TAGW:0] w_sum;
      assign w_sum          = {1'b0, r_ptr} + (TAGW+1)'(gi);
      assign w_pos[gi]      = (w_sum >= (TAGW+1)'(NREQ)) ?
                              TAGW'(w_sum - (TAGW+1)'(NREQ)) : w_sum[TAGW-1:0];
      assign w_rot_valid[gi] = req_valid[w_pos[gi]];
      assign w_lane_a[gi]   = req_a[gi*WIDTH +: WIDTH];
      assign w_lane_b[gi]   = req_b[gi*WIDTH +: WIDTH];
      assign req_ready[gi]  = w_grant_en && (w_win == TAGW'(gi));
    end
  endgenerate

  // Winner is the first valid requester at or after the round-robin pointer.
  always_comb begin
    w_win = '0;
    w_any = |w_rot_valid;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot_valid[k]) w_win = w_pos[k];
    end
  end

  // Grants only in IDLE; a flush or reset in the same cycle suppresses it.
  assign w_grant_en = (r_state == S_IDLE) && !rst && !flush && w_any;
  assign w_next_ptr = (w_win == TAGW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // One MSB-first partial-product step of the shift/XOR datapath.
  assign w_pp = r_b[r_cnt] ? ACCW'(r_a) : '0;
`ifdef GF2_REDUCE_EN
  assign w_acc_next = {r_acc[WIDTH-2:0], 1'b0} ^ (r_acc[WIDTH-1] ? POLY : '0) ^ w_pp;
`else
  logic w_unused_poly;
  assign w_unused_poly = ^POLY;
  assign w_acc_next = {r_acc[ACCW-2:0], 1'b0} ^ w_pp;
`endif

  // Scheduler/datapath FSM: accept in IDLE, WIDTH shift steps in RUN, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_a     <= w_lane_a[w_win];
            r_b     <= w_lane_b[w_win];
            r_tag   <= w_win;
            r_acc   <= '0;
            r_cnt   <= CNTW'(WIDTH - 1);
            r_ptr   <= w_next_ptr;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_next;
            if (r_cnt == '0) r_state <= S_DONE;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (flush || res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign res_tag   = r_tag;
  assign res_data  = {{(2*WIDTH-ACCW){1'b0}}, r_acc};

endmodule

// File: tb/tb_gf2_mul_sched.sv
// Self-checking bench for gf2_mul_sched: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the scheduler.
module tb_gf2_mul_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int TAGW  = 2;
  localparam logic [WIDTH-1:0] POLY = 8'h1B;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  flush;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*WIDTH-1:0]    res_data;
  logic [TAGW-1:0]       res_tag;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_ptr  = 0;

  gf2_mul_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TAGW(TAGW), .POLY(POLY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .flush(flush), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference product: polynomial multiply, then optional long division.
  function automatic logic [2*WIDTH-1:0] model_mul(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] fp;
    p = '0;
    for (int i = 0; i < WIDTH; i++)
      if (b[i]) p = p ^ ({{WIDTH{1'b0}}, a} << i);
    fp = '0;
    fp[WIDTH] = 1'b1;
    fp[WIDTH-1:0] = POLY;
`ifdef GF2_REDUCE_EN
    for (int i = 2*WIDTH-2; i >= WIDTH; i--)
      if (p[i]) p = p ^ (fp << (i - WIDTH));
`endif
    return p;
  endfunction

  // Round-robin rule: first valid requester at ptr, ptr+1, ... mod NREQ.
  function automatic int winner(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; flush = 1'b0; res_ready = 1'b0;
    next_cycle(); next_cycle();
    rst = 1'b0; m_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; flush = 1'b0; res_ready = 1'b0;
    randomize_ops();
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (res_data !== '0) begin errors++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
    checks++; if (res_tag !== '0) begin errors++; $display("FAIL reset_res_tag: got %0d expected 0", res_tag); end
    rst = 1'b0; req_valid = '0; m_ptr = 0;
    next_cycle();
    $display("reset done");
  endtask

  // One op from a single requester with exact latency and result checks.
  task automatic run_op(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2*WIDTH-1:0] exp_data, input string name);
    int lat;
    randomize_ops();
    req_a[r*WIDTH +: WIDTH] = a;
    req_b[r*WIDTH +: WIDTH] = b;
    req_valid = onehot(r); res_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== onehot(r)) begin errors++; $display("FAIL %s_grant: got %b expected %b", name, req_ready, onehot(r)); end
    next_cycle();
    req_valid = '0; m_ptr = (r + 1) % NREQ;
    randomize_ops();
    lat = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", name, busy); end
    while (lat < 20) begin
      lat++;
      if (res_valid === 1'b1) break;
      @(negedge clk);
    end
    checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, WIDTH + 1); end
    checks++; if (res_data !== exp_data) begin errors++; $display("FAIL %s_data: got %h expected %h", name, res_data, exp_data); end
    checks++; if (res_tag !== TAGW'(r)) begin errors++; $display("FAIL %s_tag: got %0d expected %0d", name, res_tag, r); end
    $display("op %s: tag=%0d a=%h b=%h data=%h latency=%0d", name, res_tag, a, b, res_data, lat);
    res_ready = 1'b1;
    next_cycle();
    res_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL %s_release: got busy=%b valid=%b expected 0/0", name, busy, res_valid); end
    next_cycle();
  endtask

  task automatic test_single_op();
`ifdef GF2_REDUCE_EN
    run_op(1, 8'h57, 8'h83, 16'h00C1, "single");
    run_op(2, 8'hFF, 8'hFF, model_mul(8'hFF, 8'hFF), "ffxff");
`else
    run_op(1, 8'h57, 8'h83, 16'h2B79, "single");
    run_op(2, 8'hFF, 8'hFF, 16'h5555, "ffxff");
`endif
    for (int i = 0; i < 3; i++) begin
      logic [WIDTH-1:0] a, b;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      run_op(int'($urandom_range(0, NREQ-1)), a, b, model_mul(a, b), "rand_single");
    end
  endtask

  task automatic test_round_robin();
    int last, w, bound;
    bit found;
    logic [2*WIDTH-1:0] exp_d;
    apply_reset();
    randomize_ops();
    req_valid = '1; res_ready = 1'b1;
    last = 0;
    for (int op = 0; op < 5; op++) begin
      w = winner(req_valid, m_ptr);
      found = 1'b0;
      for (bound = 0; bound < 30; bound++) begin
        @(negedge clk);
        if (req_ready !== '0) begin found = 1'b1; break; end
        next_cycle();
      end
      checks++; if (!found || req_ready !== onehot(w)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", op, req_ready, onehot(w)); end
      if (op > 0) begin
        checks++; if (cyc - last != WIDTH + 2) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected %0d", op, cyc - last, WIDTH + 2); end
      end
      last = cyc;
      exp_d = model_mul(req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH]);
      m_ptr = (w + 1) % NREQ;
      next_cycle();
      found = 1'b0;
      for (bound = 0; bound < 30; bound++) begin
        @(negedge clk);
        if (res_valid === 1'b1) begin found = 1'b1; break; end
      end
      checks++; if (!found || res_data !== exp_d || res_tag !== TAGW'(w)) begin errors++; $display("FAIL rr_result%0d: got %h/%0d expected %h/%0d", op, res_data, res_tag, exp_d, w); end
      $display("rr op %0d: tag=%0d data=%h", op, res_tag, res_data);
      next_cycle();
    end
    req_valid = '0; res_ready = 1'b0;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_backpressure();
    int w;
    logic [2*WIDTH-1:0] exp_d;
    randomize_ops();
    req_valid = '1; res_ready = 1'b0;
    w = winner(req_valid, m_ptr);
    exp_d = model_mul(req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH]);
    @(negedge clk);
    checks++; if (req_ready !== onehot(w)) begin errors++; $display("FAIL bp_grant: got %b expected %b", req_ready, onehot(w)); end
    next_cycle();
    m_ptr = (w + 1) % NREQ;
    randomize_ops();
    req_a[w*WIDTH +: WIDTH] = ~req_a[w*WIDTH +: WIDTH];
    repeat (WIDTH) next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_d || res_tag !== TAGW'(w) || req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b d=%h t=%0d rdy=%b busy=%b expected 1/%h/%0d/0/1", i, res_valid, res_data, res_tag, req_ready, busy, exp_d, w);
      end
      next_cycle();
    end
    res_ready = 1'b1;
    next_cycle();
    res_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== onehot(winner(req_valid, m_ptr))) begin
      errors++; $display("FAIL bp_release: got busy=%b valid=%b rdy=%b expected 0/0/%b", busy, res_valid, req_ready, onehot(winner(req_valid, m_ptr)));
    end
    $display("backpressure op: tag=%0d data=%h", w, exp_d);
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_flush();
    bit seen;
    randomize_ops();
    req_valid = onehot(2);
    @(negedge clk);
    checks++; if (req_ready !== onehot(2)) begin errors++; $display("FAIL flush_grant: got %b expected %b", req_ready, onehot(2)); end
    next_cycle();
    req_valid = '0; m_ptr = 3;
    next_cycle(); next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b valid=%b expected 0/0", busy, res_valid); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_no_result: got res_valid=1 expected 0"); end
    next_cycle();
    req_valid = '1; flush = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL flush_idle_block: got %b expected 0", req_ready); end
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ready !== onehot(3)) begin errors++; $display("FAIL flush_next_grant: got busy=%b rdy=%b expected 0/%b", busy, req_ready, onehot(3)); end
    $display("flush scenario: next grant %b", req_ready);
    req_valid = '0;
    next_cycle();
  endtask

  // Randomized traffic against a cycle model: IDLE / RUN for WIDTH cycles / DONE.
  task automatic test_random();
    int st, left, w, exp_tag;
    logic [2*WIDTH-1:0] exp_d;
    logic [NREQ-1:0] exp_rdy;
    st = 0; left = 0; exp_tag = 0; exp_d = '0;
    for (int n = 0; n < 600; n++) begin
      req_valid = NREQ'($urandom);
      randomize_ops();
      res_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      w = winner(req_valid, m_ptr);
      exp_rdy = (st == 0 && !flush) ? onehot(w) : '0;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, req_ready, exp_rdy); end
      checks++; if (busy !== (st != 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", n, busy, st != 0); end
      checks++; if (res_valid !== (st == 2)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, res_valid, st == 2); end
      if (st == 2) begin
        checks++; if (res_data !== exp_d || res_tag !== TAGW'(exp_tag)) begin errors++; $display("FAIL rnd_result@%0d: got %h/%0d expected %h/%0d", n, res_data, res_tag, exp_d, exp_tag); end
        if (res_ready || flush) $display("rnd op: tag=%0d data=%h %s", exp_tag, exp_d, flush ? "flushed" : "taken");
      end
      case (st)
        0: if (!flush && w >= 0) begin
             exp_d = model_mul(req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH]);
             exp_tag = w; left = WIDTH; st = 1; m_ptr = (w + 1) % NREQ;
           end
        1: if (flush) st = 0;
           else begin left--; if (left == 0) st = 2; end
        default: if (flush || res_ready) st = 0;
      endcase
      next_cycle();
    end
    req_valid = '0; flush = 1'b0; res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; flush = 1'b0; res_ready = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
